bulk_in_arbiter: RTL and testbench

- Round-robin, packet-granular arbiter that shares the single application IN byte stream of the bulk endpoint (app_in_data/valid/ready) among NUM_SRC independent application sources.
- Each grant lasts one burst of up to BURST_LEN bytes. When HEADER_EN=1, a one-byte source tag precedes each burst so the host can demultiplex.
- Sits in the app clock domain, between application producers and the bulk endpoint's IN FIFO write port.

---
 rtl/bulk_in_arbiter.sv | 172 +++++++++++++++++
 tb/tb_bulk_in_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bulk_in_arbiter.sv
// -----------------------------------------------------------------------------
// bulk_in_arbiter
//
// Round-robin, packet-granular arbiter. It shares the single application IN
// byte stream of the bulk endpoint among NUM_SRC application sources. Each
// grant covers one burst of up to BURST_LEN bytes. When HEADER_EN=1, the burst
// is preceded by a one-byte tag {4'hA, source index} so that the host can
// demultiplex the stream.
//
// Parameters
//   NUM_SRC    number of requesters, 2..4
//   BURST_LEN  maximum payload bytes per grant, 1..255
//   HEADER_EN  1 = emit a tag byte before each burst
//
// Ports
//   clk_i           app clock; all state updates on its rising edge
//   rst_i           synchronous reset, active-high
//   src_data_i      source bytes; source k occupies [8k+7:8k]
//   src_valid_i     per-source valid; held with stable data until consumed
//   src_ready_o     per-source consume strobe (granted source only)
//   app_in_data_o   byte to the endpoint IN path
//   app_in_valid_o  app_in_data_o is valid
//   app_in_ready_i  endpoint accepts the byte
//   grant_o         one-hot current grant; zero while idle
//   busy_o          high while a header or burst is in progress
// -----------------------------------------------------------------------------
// state | meaning
// ------+----------------------------------------------------------------------
// IDLE  | no grant; pick next requester cyclically after the last one served
// HDR   | presenting the tag byte of the granted source
// DATA  | passing the granted source straight through to the endpoint
// -----------------------------------------------------------------------------
module bulk_in_arbiter #(
   parameter int NUM_SRC   = 2,
   parameter int BURST_LEN = 8,
   parameter int HEADER_EN = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [8*NUM_SRC-1:0] src_data_i,
   input  logic [NUM_SRC-1:0]   src_valid_i,
   output logic [NUM_SRC-1:0]   src_ready_o,
   output logic [7:0]           app_in_data_o,
   output logic                 app_in_valid_o,
   input  logic                 app_in_ready_i,
   output logic [NUM_SRC-1:0]   grant_o,
   output logic                 busy_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HDR  = 2'd1;
   localparam logic [1:0] DATA = 2'd2;

   localparam logic [7:0] LAST_COUNT = 8'(BURST_LEN - 1);
   localparam logic [1:0] RST_LAST   = 2'(NUM_SRC - 1);

   logic [1:0] state;
   logic [1:0] last_idx;
   logic [1:0] grant_idx;
   logic [7:0] count;

   // Per-source signals widened to the maximum of four sources so that a
   // 2-bit index selects cleanly for every legal NUM_SRC.
   logic [3:0] valid_ext;
   logic [7:0] data_ext [4];
   logic [3:0] ready_ext;
   logic [3:0] grant_ext;

   logic       pick_found;
   logic [1:0] pick_idx;
   logic       gnt_valid;
   logic       gnt_hs;

   function automatic logic [1:0] wrap_idx(input int v);
      return 2'(v % NUM_SRC);
   endfunction

   always_comb begin
      valid_ext = '0;
      valid_ext[NUM_SRC-1:0] = src_valid_i;
      for (int k = 0; k < 4; k++) begin
         data_ext[k] = 8'h00;
      end
      for (int k = 0; k < NUM_SRC; k++) begin
         data_ext[k] = src_data_i[8*k +: 8];
      end
   end

   // Cyclic search starting just after the last source served.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         if (!pick_found && valid_ext[wrap_idx(int'(last_idx) + i)]) begin
            pick_found = 1'b1;
            pick_idx   = wrap_idx(int'(last_idx) + i);
         end
      end
   end

   assign gnt_valid = valid_ext[grant_idx];
   assign gnt_hs    = (state == DATA) && gnt_valid && app_in_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         last_idx  <= RST_LAST;
         grant_idx <= '0;
         count     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_idx <= pick_idx;
                  count     <= '0;
                  state     <= (HEADER_EN != 0) ? HDR : DATA;
               end
            end
            HDR: begin
               if (app_in_ready_i) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (gnt_hs) begin
                  count <= count + 8'd1;
                  if (count == LAST_COUNT) begin
                     state    <= IDLE;
                     last_idx <= grant_idx;
                  end
               end else if (!gnt_valid && (count != 8'd0)) begin
                  // Source went idle mid-burst: close the burst early.
                  // With count==0 we keep waiting, which only happens if the
                  // source withdrew a valid it had already raised.
                  state    <= IDLE;
                  last_idx <= grant_idx;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      app_in_data_o  = 8'h00;
      app_in_valid_o = 1'b0;
      ready_ext      = '0;
      grant_ext      = '0;
      case (state)
         HDR: begin
            app_in_valid_o       = 1'b1;
            app_in_data_o        = {4'hA, 2'b00, grant_idx};
            grant_ext[grant_idx] = 1'b1;
         end
         DATA: begin
            app_in_valid_o       = gnt_valid;
            app_in_data_o        = data_ext[grant_idx];
            ready_ext[grant_idx] = app_in_ready_i;
            grant_ext[grant_idx] = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign src_ready_o = ready_ext[NUM_SRC-1:0];
   assign grant_o     = grant_ext[NUM_SRC-1:0];
   assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_bulk_in_arbiter.sv
// Directed bench for bulk_in_arbiter. Instance A: NUM_SRC=3, BURST_LEN=8,
// HEADER_EN=1. Instance B: NUM_SRC=2, BURST_LEN=1, HEADER_EN=0.
// Payload bytes are chosen outside 0xA0..0xAF so that tag bytes can be told
// apart in the captured stream.
module tb_bulk_in_arbiter;

   logic clk = 1'b0;
   logic rst;
   logic app_ready;

   logic [23:0] a_src_data;
   logic [2:0]  a_src_valid, a_src_ready, a_grant;
   logic [7:0]  a_out_data;
   logic        a_out_valid, a_busy;

   logic [15:0] b_src_data;
   logic [1:0]  b_src_valid, b_src_ready, b_grant;
   logic [7:0]  b_out_data;
   logic        b_out_valid, b_busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int t0;
   int n;

   int         a_ptr [3];
   int         a_len [3];
   logic [7:0] a_base[3];
   int         b_ptr [2];
   int         b_len [2];
   logic [7:0] b_base[2];

   logic [7:0] a_q[$];
   int         a_qc[$];
   logic [7:0] b_q[$];
   int         b_qc[$];
   logic [7:0] exp_q[$];
   int         hc_q[$];

   logic        stall_v = 1'b0;
   logic [7:0]  stall_d = 8'h00;
   logic        bp_en   = 1'b0;
   logic [15:0] lfsr    = 16'hACE1;

   bulk_in_arbiter #(.NUM_SRC(3), .BURST_LEN(8), .HEADER_EN(1)) dut_a (
      .clk_i          (clk),
      .rst_i          (rst),
      .src_data_i     (a_src_data),
      .src_valid_i    (a_src_valid),
      .src_ready_o    (a_src_ready),
      .app_in_data_o  (a_out_data),
      .app_in_valid_o (a_out_valid),
      .app_in_ready_i (app_ready),
      .grant_o        (a_grant),
      .busy_o         (a_busy)
   );

   bulk_in_arbiter #(.NUM_SRC(2), .BURST_LEN(1), .HEADER_EN(0)) dut_b (
      .clk_i          (clk),
      .rst_i          (rst),
      .src_data_i     (b_src_data),
      .src_valid_i    (b_src_valid),
      .src_ready_o    (b_src_ready),
      .app_in_data_o  (b_out_data),
      .app_in_valid_o (b_out_valid),
      .app_in_ready_i (app_ready),
      .grant_o        (b_grant),
      .busy_o         (b_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_srcs();
      for (int k = 0; k < 3; k++) begin
         a_src_valid[k]       = (a_ptr[k] < a_len[k]);
         a_src_data[8*k +: 8] = a_base[k] + 8'(a_ptr[k]);
      end
      for (int k = 0; k < 2; k++) begin
         b_src_valid[k]       = (b_ptr[k] < b_len[k]);
         b_src_data[8*k +: 8] = b_base[k] + 8'(b_ptr[k]);
      end
   endtask

   task automatic clear_srcs();
      for (int k = 0; k < 3; k++) begin
         a_ptr[k] = 0;
         a_len[k] = 0;
         a_base[k] = 8'h00;
      end
      for (int k = 0; k < 2; k++) begin
         b_ptr[k] = 0;
         b_len[k] = 0;
         b_base[k] = 8'h00;
      end
   endtask

   function automatic bit drained();
      bit d;
      d = 1'b1;
      for (int k = 0; k < 3; k++) if (a_ptr[k] < a_len[k]) d = 1'b0;
      for (int k = 0; k < 2; k++) if (b_ptr[k] < b_len[k]) d = 1'b0;
      return d;
   endfunction

   // One clock: sample at the falling edge, then advance sources after the
   // rising edge according to the handshakes seen.
   task automatic tick();
      logic [2:0] a_hs;
      logic [1:0] b_hs;
      @(negedge clk);
      a_hs = a_src_valid & a_src_ready;
      b_hs = b_src_valid & b_src_ready;
      if (!rst) begin
         if (a_src_ready != 3'b000) chk("a_src_ready_without_app_ready", 32'(app_ready), 1);
         if (a_busy) chk("a_src_ready_outside_grant", 32'(a_src_ready & ~a_grant), 0);
         if (stall_v) begin
            chk("a_hold_valid", 32'(a_out_valid), 1);
            chk("a_hold_data", 32'(a_out_data), 32'(stall_d));
         end
         if (a_out_valid && app_ready) begin
            a_q.push_back(a_out_data);
            a_qc.push_back(cyc);
         end
         if (b_out_valid && app_ready) begin
            b_q.push_back(b_out_data);
            b_qc.push_back(cyc);
         end
         stall_v = a_out_valid && !app_ready;
         stall_d = a_out_data;
      end else begin
         stall_v = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) if (a_hs[k]) a_ptr[k]++;
      for (int k = 0; k < 2; k++) if (b_hs[k]) b_ptr[k]++;
      cyc++;
      if (bp_en) begin
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         app_ready = lfsr[0] | lfsr[5];
      end
      drive_srcs();
   endtask

   task automatic run_idle(input string tag, input int max_cyc);
      int k;
      k = 0;
      while (!(drained() && !a_busy && !b_busy) && k < max_cyc) begin
         tick();
         k++;
      end
      chk({tag, "_completes"}, 32'(k < max_cyc), 1);
   endtask

   // Compare captured A stream with exp_q; when hc_q is non-empty, also the
   // cycle (relative to t0) at which each tag byte was accepted.
   task automatic cmp_a(input string tag, input int t_ref);
      int h;
      logic [7:0] b;
      h = 0;
      chk({tag, "_len"}, 32'(a_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < a_q.size(); i++) begin
         chk({tag, "_byte"}, 32'(a_q[i]), 32'(exp_q[i]));
         b = a_q[i];
         if (hc_q.size() > 0 && b[7:4] == 4'hA) begin
            if (h < hc_q.size()) chk({tag, "_hdr_cycle"}, 32'(a_qc[i] - t_ref), 32'(hc_q[h]));
            h++;
         end
      end
      if (hc_q.size() > 0) chk({tag, "_hdr_count"}, 32'(h), 32'(hc_q.size()));
      a_q.delete();
      a_qc.delete();
   endtask

   initial begin
      rst = 1'b1;
      app_ready = 1'b1;
      clear_srcs();
      for (int k = 0; k < 3; k++) begin
         a_len[k]  = 20;
         a_base[k] = 8'(k * 8'h40);
      end
      drive_srcs();

      // Reset held two cycles with every source requesting.
      tick();
      tick();
      chk("rst_a_valid", 32'(a_out_valid), 0);
      chk("rst_a_src_ready", 32'(a_src_ready), 0);
      chk("rst_a_grant", 32'(a_grant), 0);
      chk("rst_a_busy", 32'(a_busy), 0);
      chk("rst_b_valid", 32'(b_out_valid), 0);
      chk("rst_b_grant", 32'(b_grant), 0);

      // Fairness: three sources, 20 bytes each, ready always high.
      rst = 1'b0;
      t0 = cyc;
      chk("idle_cycle_valid", 32'(a_out_valid), 0);
      tick();
      chk("first_grant_src0", 32'(a_grant), 32'h1);
      chk("first_hdr_data", 32'(a_out_data), 32'hA0);
      chk("first_hdr_valid", 32'(a_out_valid), 1);
      chk("first_busy", 32'(a_busy), 1);
      run_idle("fair", 400);
      exp_q.delete();
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 3; k++) begin
            exp_q.push_back(8'hA0 | 8'(k));
            for (int i = 0; i < ((r < 2) ? 8 : 4); i++) exp_q.push_back(a_base[k] + 8'(r * 8 + i));
         end
      end
      hc_q = '{1, 11, 21, 31, 41, 51, 61, 68, 75};
      cmp_a("fair", t0);

      // Backpressure: sources 0 and 2, ten bytes each, pseudo-random ready.
      clear_srcs();
      a_len[0] = 10; a_base[0] = 8'hC0;
      a_len[2] = 10; a_base[2] = 8'h30;
      bp_en = 1'b1;
      drive_srcs();
      run_idle("bp", 800);
      bp_en = 1'b0;
      app_ready = 1'b1;
      exp_q = '{8'hA0, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7,
                8'hA2, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                8'hA0, 8'hC8, 8'hC9, 8'hA2, 8'h38, 8'h39};
      hc_q.delete();
      cmp_a("bp", t0);

      // Single source: src1 streams 0x10..0x1B.
      clear_srcs();
      a_len[1] = 12; a_base[1] = 8'h10;
      drive_srcs();
      t0 = cyc;
      run_idle("single", 100);
      exp_q = '{8'hA1, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                8'hA1, 8'h18, 8'h19, 8'h1A, 8'h1B};
      hc_q = '{1, 11};
      cmp_a("single", t0);

      // Reset in the middle of a src0 burst.
      clear_srcs();
      a_len[0] = 20; a_base[0] = 8'h50;
      drive_srcs();
      n = 0;
      while (a_ptr[0] < 3 && n < 50) begin
         tick();
         n++;
      end
      chk("midrst_reach_3_bytes", 32'(a_ptr[0]), 3);
      chk("midrst_busy_before", 32'(a_busy), 1);
      rst = 1'b1;
      app_ready = 1'b0;
      tick();
      chk("midrst_valid", 32'(a_out_valid), 0);
      chk("midrst_grant", 32'(a_grant), 0);
      chk("midrst_busy", 32'(a_busy), 0);
      chk("midrst_src_ready", 32'(a_src_ready), 0);
      rst = 1'b0;
      app_ready = 1'b1;
      a_len[1] = 5; a_base[1] = 8'h70;
      a_len[2] = 5; a_base[2] = 8'h90;
      drive_srcs();
      chk("midrst_idle_valid", 32'(a_out_valid), 0);
      tick();
      chk("midrst_regrant_src0", 32'(a_grant), 32'h1);
      chk("midrst_new_hdr", 32'(a_out_data), 32'hA0);
      tick();
      chk("midrst_resume_byte", 32'(a_out_data), 32'h53);
      chk("midrst_resume_valid", 32'(a_out_valid), 1);
      rst = 1'b1;
      clear_srcs();
      drive_srcs();
      tick();
      tick();
      rst = 1'b0;
      a_q.delete();
      a_qc.delete();
      b_q.delete();
      b_qc.delete();

      // No tag, one-byte bursts: src0 and src1 alternate with an idle gap.
      b_len[0] = 4; b_base[0] = 8'h20;
      b_len[1] = 4; b_base[1] = 8'h60;
      drive_srcs();
      t0 = cyc;
      run_idle("nohdr", 100);
      exp_q = '{8'h20, 8'h60, 8'h21, 8'h61, 8'h22, 8'h62, 8'h23, 8'h63};
      chk("nohdr_len", 32'(b_q.size()), 8);
      for (int i = 0; i < 8 && i < b_q.size(); i++) begin
         chk("nohdr_byte", 32'(b_q[i]), 32'(exp_q[i]));
         chk("nohdr_cycle", 32'(b_qc[i] - t0), 32'(2 * i + 1));
      end
      chk("nohdr_a_quiet", 32'(a_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
